// File: rtl/spi_frame_sequencer.sv
// Splits a 14-bit word into two SPI bytes (high first) under one ss window and reassembles the echoed bytes.
// Frame takes 1+SS_SETUP+1+T_hi+GAP_CYCLES+1+T_lo+1 cycles; o_ready only in IDLE, no request queuing.
module spi_frame_sequencer #(
  parameter int SS_SETUP   = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [13:0] i_data,
  output logic        o_ready,
  output logic        o_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_done,
  input  logic [7:0]  i_rx_data,
  output logic        ss,
  output logic [13:0] o_rx_word,
  output logic        o_rx_valid,
  output logic        o_match,
  output logic        o_err,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HIGH = 3'd1,
    WAIT_HIGH = 3'd2,
    SEND_LOW  = 3'd3,
    WAIT_LOW  = 3'd4,
    SETUP     = 3'd5,
    GAP       = 3'd6,
    FINISH    = 3'd7
  } state_t;

  // Zero-length setup/gap/timeout are clamped to one cycle.
  localparam int SETUP_N   = (SS_SETUP < 1) ? 1 : SS_SETUP;
  localparam int GAP_N     = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int TO_N      = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int PHASE_MAX = (SETUP_N > GAP_N) ? SETUP_N : GAP_N;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TO_N + 1);

  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_N - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_N - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TO_N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] to_cnt;
  logic [13:0]   tx_word;
  logic [7:0]    rx_hi;
  logic [7:0]    rx_lo;

  logic ld_tx;
  logic ld_hi_byte;
  logic ld_lo_byte;
  logic cap_hi;
  logic cap_lo;
  logic abort;
  logic finish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_tx      = 1'b0;
    ld_hi_byte = 1'b0;
    ld_lo_byte = 1'b0;
    cap_hi     = 1'b0;
    cap_lo     = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          ld_tx     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (phase_cnt == SETUP_LAST) begin
          ld_hi_byte = 1'b1;
          state_nxt  = SEND_HIGH;
        end
      end
      SEND_HIGH: state_nxt = WAIT_HIGH;
      WAIT_HIGH: begin
        // A done arriving in the last allowed cycle still completes the byte.
        if (i_done) begin
          cap_hi    = 1'b1;
          state_nxt = GAP;
        end else if (to_cnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (phase_cnt == GAP_LAST) begin
          ld_lo_byte = 1'b1;
          state_nxt  = SEND_LOW;
        end
      end
      SEND_LOW: state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (i_done) begin
          cap_lo    = 1'b1;
          state_nxt = FINISH;
        end else if (to_cnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if ((state == SETUP || state == GAP) && state_nxt == state) begin
      phase_cnt <= phase_cnt + PW'(1);
    end else begin
      phase_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if ((state == WAIT_HIGH || state == WAIT_LOW) && state_nxt == state) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_word   <= '0;
      o_tx_data <= '0;
      rx_hi     <= '0;
      rx_lo     <= '0;
    end else begin
      if (ld_tx) begin
        tx_word <= i_data;
      end
      // Loaded on entry to SEND so the byte is stable from o_start until done.
      if (ld_hi_byte) begin
        o_tx_data <= {2'b00, tx_word[13:8]};
      end else if (ld_lo_byte) begin
        o_tx_data <= tx_word[7:0];
      end
      if (cap_hi) begin
        rx_hi <= i_rx_data;
      end
      if (cap_lo) begin
        rx_lo <= i_rx_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss         <= 1'b1;
      o_rx_word  <= '0;
      o_rx_valid <= 1'b0;
      o_match    <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_rx_valid <= finish;
      o_err      <= abort;
      if (ld_tx) begin
        ss <= 1'b0;
      end else if (abort || finish) begin
        ss <= 1'b1;
      end
      if (finish) begin
        o_rx_word <= {rx_hi[5:0], rx_lo};
        o_match   <= ({rx_hi[5:0], rx_lo} == tx_word) && (rx_hi[7:6] == 2'b00);
      end
    end
  end

  assign o_ready = (state == IDLE);
  assign o_start = (state == SEND_HIGH) || (state == SEND_LOW);
  assign o_state = state;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: behavioural SPI responder, output monitor and a frame-level model of the expected bytes/word.
module tb_spi_frame_sequencer;

  localparam int SETUP_C = 2;
  localparam int GAP_C   = 4;
  localparam int TO_C    = 64;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [13:0] i_data;
  logic        o_ready;
  logic        o_start;
  logic [7:0]  o_tx_data;
  logic        i_done;
  logic [7:0]  i_rx_data;
  logic        ss;
  logic [13:0] o_rx_word;
  logic        o_rx_valid;
  logic        o_match;
  logic        o_err;
  logic [2:0]  o_state;

  logic resp_done;
  logic spur_done;
  assign i_done = resp_done | spur_done;

  int         dly_hi;
  int         dly_lo;
  bit         echo;
  logic [7:0] rsp_hi;
  logic [7:0] rsp_lo;

  int vectors;
  int miscompares;

  int          cyc;
  logic [7:0]  sent_q[$];
  logic [13:0] rxw_q[$];
  logic        rxm_q[$];
  logic [2:0]  trace_q[$];
  int          high_q[$];
  int          n_err;
  int          err_cyc;
  int          wl_cyc;
  logic        err_ss;
  logic [2:0]  err_state;
  logic [2:0]  prev_state;
  int          cur_gap;
  int          last_gap;
  int          low_run;
  int          high_run;
  int          last_low;
  int          bad_start;
  int          bad_ready;

  spi_frame_sequencer #(
    .SS_SETUP  (SETUP_C),
    .GAP_CYCLES(GAP_C),
    .TIMEOUT   (TO_C)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_start   (o_start),
    .o_tx_data (o_tx_data),
    .i_done    (i_done),
    .i_rx_data (i_rx_data),
    .ss        (ss),
    .o_rx_word (o_rx_word),
    .o_rx_valid(o_rx_valid),
    .o_match   (o_match),
    .o_err     (o_err),
    .o_state   (o_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI core model: answers each o_start after the configured number of wait cycles.
  initial begin
    int         byte_no;
    int         d;
    logic [7:0] tx_b;
    bit         hi;
    resp_done = 1'b0;
    i_rx_data = 8'h00;
    byte_no   = 0;
    forever begin
      @(negedge clk);
      if (ss) begin
        byte_no = 0;
      end else if (o_start) begin
        tx_b    = o_tx_data;
        hi      = (byte_no == 0);
        byte_no = byte_no + 1;
        d       = hi ? dly_hi : dly_lo;
        if (d <= 200) begin
          repeat (d) @(negedge clk);
          resp_done = 1'b1;
          i_rx_data = echo ? tx_b : (hi ? rsp_hi : rsp_lo);
          @(negedge clk);
          resp_done = 1'b0;
        end
      end
    end
  end

  initial begin
    cyc = 0; n_err = 0; err_cyc = 0; wl_cyc = 0; err_ss = 1'b0; err_state = 3'd0;
    prev_state = 3'd0; cur_gap = 0; last_gap = 0; low_run = 0; high_run = 0;
    last_low = 0; bad_start = 0; bad_ready = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (o_start) begin
        sent_q.push_back(o_tx_data);
        if (ss) bad_start = bad_start + 1;
      end
      if (o_ready && o_state != 3'd0) bad_ready = bad_ready + 1;
      if (o_rx_valid) begin
        rxw_q.push_back(o_rx_word);
        rxm_q.push_back(o_match);
      end
      if (o_err) begin
        n_err     = n_err + 1;
        err_cyc   = cyc;
        err_ss    = ss;
        err_state = o_state;
      end
      if (o_state != prev_state) begin
        trace_q.push_back(o_state);
        if (o_state == 3'd4) wl_cyc = cyc;
      end
      prev_state = o_state;
      if (o_state == 3'd6) begin
        cur_gap = cur_gap + 1;
      end else if (cur_gap != 0) begin
        last_gap = cur_gap;
        cur_gap  = 0;
      end
      if (!ss) begin
        low_run = low_run + 1;
        if (high_run != 0) begin
          high_q.push_back(high_run);
          high_run = 0;
        end
      end else begin
        high_run = high_run + 1;
        if (low_run != 0) begin
          last_low = low_run;
          low_run  = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [13:0] w, input bit keep);
    int n;
    i_data  = w;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 600) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(o_ready), 32'd1);
    tick();
    if (!keep) i_valid = 1'b0;
  endtask

  task automatic wait_end(input int b_rx, input int b_err);
    int n;
    n = 0;
    while (rxw_q.size() == b_rx && n_err == b_err && n < 600) begin
      tick();
      n++;
    end
    check("frame_end_seen", 32'(rxw_q.size() != b_rx || n_err != b_err), 32'd1);
  endtask

  task automatic run_frame(input logic [13:0] w, input int dh, input int dl, input bit em,
                           input logic [7:0] rh, input logic [7:0] rl, input string tag);
    int          b_rx;
    int          b_err;
    int          b_sent;
    logic [7:0]  exp_hb;
    logic [7:0]  exp_lb;
    logic [7:0]  got_hi;
    logic [7:0]  got_lo;
    logic [13:0] exp_w;
    bit          exp_m;
    bit          exp_e;
    dly_hi = dh; dly_lo = dl; echo = em; rsp_hi = rh; rsp_lo = rl;
    b_rx   = rxw_q.size();
    b_err  = n_err;
    b_sent = sent_q.size();
    send(w, 1'b0);
    wait_end(b_rx, b_err);
    exp_hb = {2'b00, w[13:8]};
    exp_lb = w[7:0];
    exp_e  = (dh > TO_C) || (dl > TO_C);
    check({tag, "_nbytes"}, 32'(sent_q.size() - b_sent), (dh > TO_C) ? 32'd1 : 32'd2);
    check({tag, "_hibyte"}, 32'(sent_q[b_sent]), 32'(exp_hb));
    if (dh <= TO_C) check({tag, "_lobyte"}, 32'(sent_q[b_sent + 1]), 32'(exp_lb));
    check({tag, "_err"}, 32'(n_err - b_err), exp_e ? 32'd1 : 32'd0);
    check({tag, "_rxvalid"}, 32'(rxw_q.size() - b_rx), exp_e ? 32'd0 : 32'd1);
    if (!exp_e && rxw_q.size() > b_rx) begin
      got_hi = em ? exp_hb : rh;
      got_lo = em ? exp_lb : rl;
      exp_w  = {got_hi[5:0], got_lo};
      exp_m  = (exp_w == w) && (got_hi[7:6] == 2'b00);
      check({tag, "_rxword"}, 32'(rxw_q[b_rx]), 32'(exp_w));
      check({tag, "_match"}, 32'(rxm_q[b_rx]), 32'(exp_m));
    end
    repeat (6) tick();
  endtask

  initial begin
    int          n;
    int          b_rx;
    int          b_err;
    int          b_sent;
    int          b_tr;
    logic [13:0] bw[3];
    logic [2:0]  exp_tr[8];
    logic [13:0] rw;
    int          rdh;
    int          rdl;

    vectors = 0; miscompares = 0;
    i_valid = 1'b0; i_data = 14'h0; spur_done = 1'b0;
    dly_hi = 1; dly_lo = 1; echo = 1'b1; rsp_hi = 8'h00; rsp_lo = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();

    check("rst_state", 32'(o_state), 32'd0);
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_start", 32'(o_start), 32'd0);
    check("rst_txdata", 32'(o_tx_data), 32'd0);
    check("rst_rxword", 32'(o_rx_word), 32'd0);
    check("rst_rxvalid", 32'(o_rx_valid), 32'd0);
    check("rst_match", 32'(o_match), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    reset = 1'b0;
    repeat (3) tick();

    run_frame(14'h1A5C, 20, 20, 1'b1, 8'h00, 8'h00, "loop");
    check("loop_ss_low_len", 32'(last_low), 32'(SETUP_C + 1 + 20 + GAP_C + 1 + 20 + 1));

    run_frame(14'h015C, 9, 11, 1'b0, 8'hC1, 8'h5C, "corrupt");

    run_frame(14'h2A55, 20, 999, 1'b1, 8'h00, 8'h00, "tmo");
    check("tmo_err_delay", 32'(err_cyc - wl_cyc), 32'(TO_C));
    check("tmo_err_ss", 32'(err_ss), 32'd1);
    check("tmo_err_state", 32'(err_state), 32'd0);
    check("tmo_rxword_held", 32'(o_rx_word), 32'h015C);

    bw[0] = 14'h0001; bw[1] = 14'h3FFF; bw[2] = 14'h2000;
    dly_hi = 3; dly_lo = 3; echo = 1'b1;
    b_rx   = rxw_q.size();
    b_sent = sent_q.size();
    send(bw[0], 1'b1);
    send(bw[1], 1'b1);
    send(bw[2], 1'b0);
    n = 0;
    while (rxw_q.size() < b_rx + 3 && n < 600) begin
      tick();
      n++;
    end
    check("b2b_frames", 32'(rxw_q.size() - b_rx), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("b2b_rxword", 32'(rxw_q[b_rx + k]), 32'(bw[k]));
      check("b2b_match", 32'(rxm_q[b_rx + k]), 32'd1);
      check("b2b_hibyte", 32'(sent_q[b_sent + 2 * k]), 32'({2'b00, bw[k][13:8]}));
      check("b2b_lobyte", 32'(sent_q[b_sent + 2 * k + 1]), 32'(bw[k][7:0]));
    end
    check("b2b_idle_gap1", 32'(high_q[high_q.size() - 2]), 32'd1);
    check("b2b_idle_gap2", 32'(high_q[high_q.size() - 1]), 32'd1);
    repeat (6) tick();

    dly_hi = 5; dly_lo = 5; echo = 1'b1;
    b_rx  = rxw_q.size();
    b_err = n_err;
    send(14'h2AAA, 1'b0);
    n = 0;
    while (o_state != 3'd6 && n < 200) begin
      tick();
      n++;
    end
    check("rst_mid_in_gap", 32'(o_state), 32'd6);
    reset = 1'b1;
    #1;
    check("rst_mid_ss", 32'(ss), 32'd1);
    check("rst_mid_state", 32'(o_state), 32'd0);
    check("rst_mid_start", 32'(o_start), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("rst_mid_no_err", 32'(n_err - b_err), 32'd0);
    check("rst_mid_no_rxv", 32'(rxw_q.size() - b_rx), 32'd0);
    run_frame(14'h0123, 7, 9, 1'b1, 8'h00, 8'h00, "post_rst");

    exp_tr = '{3'd5, 3'd1, 3'd2, 3'd6, 3'd3, 3'd4, 3'd7, 3'd0};
    dly_hi = 6; dly_lo = 8; echo = 1'b1;
    b_rx  = rxw_q.size();
    b_err = n_err;
    b_tr  = trace_q.size();
    send(14'h2B3C, 1'b0);
    check("spur_in_setup", 32'(o_state), 32'd5);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    n = 0;
    while (o_state != 3'd6 && n < 200) begin
      tick();
      n++;
    end
    check("spur_in_gap", 32'(o_state), 32'd6);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    wait_end(b_rx, b_err);
    check("spur_trace_len", 32'(trace_q.size() - b_tr), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (b_tr + k < trace_q.size()) check("spur_trace", 32'(trace_q[b_tr + k]), 32'(exp_tr[k]));
    end
    check("spur_gap_len", 32'(last_gap), 32'(GAP_C));
    check("spur_rxword", 32'(rxw_q[b_rx]), 32'h2B3C);
    check("spur_match", 32'(rxm_q[b_rx]), 32'd1);
    repeat (6) tick();

    for (int k = 0; k < 16; k++) begin
      rw  = 14'($urandom);
      rdh = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 12)) : int'($urandom_range(62, 66));
      rdl = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 12)) : int'($urandom_range(62, 66));
      run_frame(rw, rdh, rdl, ($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom), "rnd");
    end

    check("start_while_ss_high", 32'(bad_start), 32'd0);
    check("ready_outside_idle", 32'(bad_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
